spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Round-robin scheduler that shares one SPI master (transmitter/receiver pair) between N_REQ requesters.
- For each transaction it latches the winning requester's byte and SPI mode, then drives the master's strt/data_in/CKP/CPH.
- It tracks the transaction through the master's CS, then returns the received byte, or a timeout error, to that requester only.
- Sits between CPU-side peripherals and the SPI master; the master itself is unchanged.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDX_W, 2, requester index width = clog2(N_REQ)
TIMEOUT, 255, max clk cycles allowed in any wait state before abort
TO_W, 8, timeout counter width (must hold TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  N_REQ  per-requester request level; held until ack
req_data  in  8*N_REQ  per-requester TX byte, slice i = [8i+7:8i]
req_mode  in  2*N_REQ  per-requester {CKP,CPH}, slice i = [2i+1:2i]
ack  out  N_REQ  one-hot, 1-cycle pulse: transaction for requester i finished
err  out  1  valid with ack; 1 = timeout abort
rx_data  out  8  received byte, valid with ack
busy  out  1  high from grant until ack
spi_strt  out  1  start pulse to SPI master
spi_data_in  out  8  TX byte to SPI master
spi_ckp  out  1  clock polarity to SPI master
spi_cph  out  1  clock phase to SPI master
spi_cs  in  1  SPI master chip select, active low
spi_rx_data  in  8  byte shifted in by SPI master, stable once CS rises

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE; ack=0, err=0, rx_data=0, busy=0, spi_strt=0, spi_data_in=0, spi_ckp=0, spi_cph=0; rr pointer=0; timeout counter=0. rst mid-transaction aborts with no ack; spi_strt drops immediately, and the master recovers via its own reset.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, RESPOND.
- IDLE: if any req bit is set, grant the first set bit searching upward from rr pointer, wrapping at N_REQ. Latch grant index, req_data slice and req_mode slice into spi_data_in/spi_ckp/spi_cph. Set busy=1 and go to LAUNCH. Otherwise remain in IDLE.
- LAUNCH: spi_strt=1 for exactly one cycle; clear the timeout counter; go to WAIT_LOW.
- WAIT_LOW: wait for spi_cs=0, then go to WAIT_HIGH and clear the counter.
- WAIT_HIGH: wait for spi_cs=1, then capture spi_rx_data into rx_data, set err=0 and go to RESPOND.
- Timeout: in WAIT_LOW or WAIT_HIGH the counter increments each cycle. When it reaches TIMEOUT: err=1, rx_data=0, go to RESPOND.
- RESPOND: ack[grant]=1 for one cycle; busy=0; rr pointer = grant+1 (mod N_REQ); go to IDLE.
- The requester must drop req in the cycle after ack. A req still high in the next IDLE is treated as a new request.
- Minimum grant-to-ack latency (cycles): 1 (LAUNCH) + CS-low wait + CS-high wait + 1 (RESPOND).
- Back-to-back: IDLE is always visited for 1 cycle between transactions, giving CS a guaranteed idle gap.
- spi_data_in/spi_ckp/spi_cph stay stable from LAUNCH through RESPOND. Requester changes to req_data or req_mode after grant are ignored.
- Simultaneous requests: the rr pointer decides. After serving i, index i has lowest priority.
- A req dropping before grant loses the request. A req dropping after grant does not cancel the transaction; ack is still issued.
- spi_cs=0 already in IDLE (master stuck) does not block the grant. WAIT_LOW is satisfied immediately, and completion is still detected on the subsequent CS rise.

Decomposition:
- Shared package spi_pkg: state encodings (3-bit), SPI mode constants MODE00..MODE11 as {CKP,CPH}, byte width 8.
- One sub-module: spi_rr_arbiter. Combinational round-robin priority pick: inputs req, rr pointer; outputs grant index and any-valid.
- FSM, timeout counter and data latching stay in the top module.

Test Plan:
- Single requester: req[1]=1, data 8'hA5, mode 2'b01. Model master pulls CS low 2 cycles after strt and high 40 cycles later with rx 8'h3C. Expect spi_ckp=0, spi_cph=1, spi_data_in=A5, one strt pulse, then ack=4'b0010, rx_data=3C, err=0.
- Contention: req=4'b1111 held, each reasserted after ack. Expect grant order 0,1,2,3,0, with one IDLE cycle between each CS-high and the next strt.
- Timeout: CS never falls after strt. Expect ack on the requester TIMEOUT+2 cycles after strt with err=1, rx_data=00, busy=0, and the next request is served normally.
- Mid-transaction reset: assert rst during WAIT_HIGH. Expect all outputs 0 the next cycle, no ack, and rr pointer=0.
- Late data change: change req_data[0] from 8'h11 to 8'hFF during WAIT_HIGH. Expect spi_data_in held at 11.
- Request withdrawn: drop req[2] one cycle before it would be granted. Expect no strt and the arbiter returns to IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
package spi_pkg;

  localparam int unsigned BYTE_W = 8;

  // Arbiter FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_RESPOND   = 3'd4
  } state_e;

  // SPI modes as {CKP, CPH}
  localparam logic [1:0] MODE00 = 2'b00;
  localparam logic [1:0] MODE01 = 2'b01;
  localparam logic [1:0] MODE10 = 2'b10;
  localparam logic [1:0] MODE11 = 2'b11;

  // Per-transaction settings latched at grant and presented to the master
  typedef struct packed {
    logic              ckp;
    logic              cph;
    logic [BYTE_W-1:0] data;
  } spi_cfg_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module spi_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             valid_o
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  // Scan upward from the pointer; the first hit wins
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      if (!valid_o && req_i[wrap_idx(rr_ptr_i, off)]) begin
        grant_o = wrap_idx(rr_ptr_i, off);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin scheduler sharing one SPI master between N_REQ requesters.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [2*N_REQ-1:0]      req_mode,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic [BYTE_W-1:0]       rx_data,
  output logic                    busy,
  output logic                    spi_strt,
  output logic [BYTE_W-1:0]       spi_data_in,
  output logic                    spi_ckp,
  output logic                    spi_cph,
  input  logic                    spi_cs,
  input  logic [BYTE_W-1:0]       spi_rx_data
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  spi_cfg_t            cfg_q, cfg_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                err_q, err_d;
  logic [BYTE_W-1:0]   rx_q, rx_d;
  logic                busy_q, busy_d;
  logic                strt_q, strt_d;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_vld;

  spi_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i    (req),
    .rr_ptr_i (rr_q),
    .grant_o  (pick_idx),
    .valid_o  (pick_vld)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    ack_d   = '0;
    err_d   = err_q;
    rx_d    = rx_q;
    busy_d  = busy_q;
    strt_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d  = pick_idx;
          cfg_d.data = req_data[BYTE_W*32'(pick_idx) +: BYTE_W];
          {cfg_d.ckp, cfg_d.cph} = req_mode[2*32'(pick_idx) +: 2];
          busy_d  = 1'b1;
          strt_d  = 1'b1;
          state_d = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_LOW;
      end

      ST_WAIT_LOW: begin
        if (!spi_cs) begin
          cnt_d   = '0;
          state_d = ST_WAIT_HIGH;
        end else if (cnt_q == TO_LIMIT) begin
          err_d   = 1'b1;
          rx_d    = '0;
          ack_d   = N_REQ'(1) << grant_q;
          busy_d  = 1'b0;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      ST_WAIT_HIGH: begin
        if (spi_cs) begin
          err_d   = 1'b0;
          rx_d    = spi_rx_data;
          ack_d   = N_REQ'(1) << grant_q;
          busy_d  = 1'b0;
          state_d = ST_RESPOND;
        end else if (cnt_q == TO_LIMIT) begin
          err_d   = 1'b1;
          rx_d    = '0;
          ack_d   = N_REQ'(1) << grant_q;
          busy_d  = 1'b0;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      ST_RESPOND: begin
        // Just-served requester drops to lowest priority
        if (32'(grant_q) + 32'd1 >= N_REQ) rr_d = '0;
        else                               rr_d = grant_q + IDX_W'(1);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      cfg_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rx_q    <= '0;
      busy_q  <= 1'b0;
      strt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      strt_q  <= strt_d;
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign rx_data     = rx_q;
  assign busy        = busy_q;
  assign spi_strt    = strt_q;
  assign spi_data_in = cfg_q.data;
  assign spi_ckp     = cfg_q.ckp;
  assign spi_cph     = cfg_q.cph;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter with a simple SPI master model.
module tb_spi_txn_arbiter;
  import spi_pkg::*;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned TIMEOUT = 255;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [8*N_REQ-1:0]      req_data;
  logic [2*N_REQ-1:0]      req_mode;
  logic [N_REQ-1:0]        ack;
  logic                    err;
  logic [7:0]              rx_data;
  logic                    busy;
  logic                    spi_strt;
  logic [7:0]              spi_data_in;
  logic                    spi_ckp;
  logic                    spi_cph;
  logic                    spi_cs;
  logic [7:0]              spi_rx_data;

  typedef struct packed {
    logic [1:0] idx;
    logic       err;
    logic [7:0] rx;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  // master model controls
  logic       m_hang;
  logic [7:0] m_xor;
  logic [7:0] m_rx;
  logic       m_busy;
  int         m_cnt;

  spi_txn_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .req_mode    (req_mode),
    .ack         (ack),
    .err         (err),
    .rx_data     (rx_data),
    .busy        (busy),
    .spi_strt    (spi_strt),
    .spi_data_in (spi_data_in),
    .spi_ckp     (spi_ckp),
    .spi_cph     (spi_cph),
    .spi_cs      (spi_cs),
    .spi_rx_data (spi_rx_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_strt(input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (spi_strt === 1'b1) break;
    end
    chk(name, 32'(spi_strt), 32'd1);
  endtask

  task automatic wait_ack(input string name, input int budget, output int idx, output int lat);
    idx = -1;
    lat = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      lat++;
      if (ack !== '0) break;
    end
    chk(name, 32'(ack !== '0), 32'd1);
    for (int i = 0; i < int'(N_REQ); i++) if (ack[i] === 1'b1) idx = i;
  endtask

  // SPI master model: CS low 2 cycles after strt, high 40 cycles later
  initial begin
    spi_cs      = 1'b1;
    spi_rx_data = 8'h00;
    m_busy      = 1'b0;
    m_cnt       = 0;
    m_rx        = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_busy = 1'b0;
        spi_cs = 1'b1;
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == 2) spi_cs = 1'b0;
        else if (m_cnt == 42) begin
          spi_rx_data = m_rx;
          spi_cs      = 1'b1;
          m_busy      = 1'b0;
        end
      end else if (spi_strt === 1'b1 && !m_hang) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_rx   = spi_data_in ^ m_xor;
      end
    end
  end

  // Monitor: every ack is matched against the next expected response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && ack !== '0) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", 32'(ack), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_onehot", 32'(ack), 32'd1 << e.idx);
          chk("ack_err", 32'(err), 32'(e.err));
          chk("ack_rx_data", 32'(rx_data), 32'(e.rx));
          chk("ack_busy_low", 32'(busy), 32'd0);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int idx;
    int lat;
    logic seen;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    req_mode = '0;
    m_hang   = 1'b0;
    m_xor    = 8'h99;

    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strt", 32'(spi_strt), 32'd0);
    chk("rst_data_in", 32'(spi_data_in), 32'd0);
    chk("rst_ckp", 32'(spi_ckp), 32'd0);
    chk("rst_cph", 32'(spi_cph), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Contention: all four held, expect 0,1,2,3,0
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    sb.push_back('{idx: 2'd0, err: 1'b0, rx: 8'h88});
    sb.push_back('{idx: 2'd1, err: 1'b0, rx: 8'hBB});
    sb.push_back('{idx: 2'd2, err: 1'b0, rx: 8'hAA});
    sb.push_back('{idx: 2'd3, err: 1'b0, rx: 8'hDD});
    sb.push_back('{idx: 2'd0, err: 1'b0, rx: 8'h88});
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack("cont_ack_seen", 200, idx, lat);
      if (idx < 0) break;
      if (k == 4) begin
        req = '0;
      end else begin
        req[idx] = 1'b0;
        @(negedge clk);
        chk("cont_idle_gap", 32'(spi_strt), 32'd0);
        @(negedge clk);
        chk("cont_strt_after_gap", 32'(spi_strt), 32'd1);
        req[idx] = 1'b1;
      end
    end
    repeat (2) @(negedge clk);

    // Single requester 1, mode 01
    req_data[15:8] = 8'hA5;
    req_mode[3:2]  = MODE01;
    sb.push_back('{idx: 2'd1, err: 1'b0, rx: 8'h3C});
    req[1] = 1'b1;
    wait_strt("single_strt_seen");
    chk("single_ckp", 32'(spi_ckp), 32'd0);
    chk("single_cph", 32'(spi_cph), 32'd1);
    chk("single_data_in", 32'(spi_data_in), 32'hA5);
    chk("single_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("single_strt_pulse", 32'(spi_strt), 32'd0);
    wait_ack("single_ack_seen", 200, idx, lat);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout: master never drops CS
    m_hang = 1'b1;
    req_data[31:24] = 8'h77;
    req_mode[7:6]   = MODE11;
    sb.push_back('{idx: 2'd3, err: 1'b1, rx: 8'h00});
    req[3] = 1'b1;
    wait_strt("to_strt_seen");
    chk("to_ckp", 32'(spi_ckp), 32'd1);
    chk("to_cph", 32'(spi_cph), 32'd1);
    wait_ack("to_ack_seen", 400, idx, lat);
    chk("to_latency", 32'(lat), 32'(TIMEOUT + 2));
    req[3] = 1'b0;
    m_hang = 1'b0;
    repeat (2) @(negedge clk);

    // Next request served normally; late req_data change ignored
    req_data[7:0] = 8'h11;
    sb.push_back('{idx: 2'd0, err: 1'b0, rx: 8'h88});
    req[0] = 1'b1;
    wait_strt("late_strt_seen");
    repeat (10) @(negedge clk);
    req_data[7:0] = 8'hFF;
    @(negedge clk);
    chk("late_data_held", 32'(spi_data_in), 32'h11);
    wait_ack("late_ack_seen", 200, idx, lat);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Mid-transaction reset in WAIT_HIGH
    req_data[23:16] = 8'h42;
    req[2] = 1'b1;
    wait_strt("mrst_strt_seen");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ack", 32'(ack), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_rx_data", 32'(rx_data), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_strt", 32'(spi_strt), 32'd0);
    chk("mrst_data_in", 32'(spi_data_in), 32'd0);
    req = '0;
    rst = 1'b0;
    @(negedge clk);

    // Pointer back at 0: requesters 0 and 3 pending, 0 wins
    req_data[7:0] = 8'h5A;
    sb.push_back('{idx: 2'd0, err: 1'b0, rx: 8'hC3});
    req = 4'b1001;
    wait_strt("rr_strt_seen");
    chk("rr_data_in", 32'(spi_data_in), 32'h5A);
    req[2] = 1'b1;
    wait_ack("rr_ack_seen", 200, idx, lat);
    // Withdraw everything in the ack cycle, right before the next grant
    req = '0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (spi_strt !== 1'b0) seen = 1'b1;
    end
    chk("withdrawn_no_strt", 32'(seen), 32'd0);
    chk("withdrawn_busy", 32'(busy), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
